// File: rtl/i2c_master_wr_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_master_wr_ctrl_if
//  Description : Host handshake and I2C bus-side signal bundle for the
//                single-master I2C write sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2c_master_wr_ctrl_if #(
  parameter int ADDR_W = 7
);
  // Host side
  logic              i_start;
  logic [ADDR_W-1:0] i_addr;
  logic [15:0]       i_data;
  logic              o_busy;
  logic              o_done;
  logic              o_nack;
  logic [15:0]       o_data;
  // Bus side
  logic              i_sda_in;
  logic              o_scl;
  logic              o_sda;
  logic              o_scl_en;
  logic              o_sda_en;

  modport master (
    input  i_start, i_addr, i_data, i_sda_in,
    output o_busy, o_done, o_nack, o_data,
    output o_scl, o_sda, o_scl_en, o_sda_en
  );

  modport slave (
    output i_start, i_addr, i_data, i_sda_in,
    input  o_busy, o_done, o_nack, o_data,
    input  o_scl, o_sda, o_scl_en, o_sda_en
  );
endinterface
`default_nettype wire

// File: rtl/i2c_master_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_master_wr_ctrl
//  Description : Single-master I2C write sequencer. One request issues
//                START, addr+W, ACK, data[15:8], ACK, data[7:0], ACK, STOP.
//                A NACK in any ACK slot skips straight to STOP.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_master_wr_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 7
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  i2c_master_wr_ctrl_if.master bus
);

  localparam int unsigned       c_DIV_W    = $clog2(CLK_DIV);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_START  = 4'd1,
    ST_ADDR   = 4'd2,
    ST_ACK_A  = 4'd3,
    ST_DATA_H = 4'd4,
    ST_ACK_H  = 4'd5,
    ST_DATA_L = 4'd6,
    ST_ACK_L  = 4'd7,
    ST_STOP   = 4'd8
  } state_t;

  state_t             state_q, state_d;
  logic [c_DIV_W-1:0] div_q, div_d;
  logic [1:0]         qtr_q, qtr_d;
  logic [2:0]         bit_q, bit_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [15:0]        data_q, data_d;
  logic               nack_q, nack_d;
  logic               done_q, done_d;

  logic               w_tick;
  logic               w_slot_end;
  logic               w_ack_slot;
  logic [7:0]         w_byte;
  logic               w_bit;
  logic               w_scl, w_sda, w_scl_en, w_sda_en;

  assign w_tick     = (div_q == c_DIV_LAST);
  assign w_slot_end = w_tick && (qtr_q == 2'd3);
  assign w_ack_slot = (state_q == ST_ACK_A) || (state_q == ST_ACK_H) ||
                      (state_q == ST_ACK_L);

  // Byte currently being shifted out; address slot appends the W bit (0)
  always_comb begin
    w_byte = data_q[7:0];
    case (state_q)
      ST_ADDR:   w_byte = {addr_q, 1'b0};
      ST_DATA_H: w_byte = data_q[15:8];
      default:   w_byte = data_q[7:0];
    endcase
  end

  assign w_bit = w_byte[3'd7 - bit_q];

  // State, timing counters and latched request
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      nack_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      nack_q  <= nack_d;
      done_q  <= done_d;
    end
  end

  // Next-state: accept in IDLE, advance quarters on divider ticks, move on
  // slot boundaries; ACK is sampled on the tick that ends q2
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    addr_d  = addr_q;
    data_d  = data_q;
    nack_d  = nack_q;
    done_d  = 1'b0;

    if (state_q == ST_IDLE) begin
      if (bus.i_start) begin
        state_d = ST_START;
        addr_d  = bus.i_addr;
        data_d  = bus.i_data;
        nack_d  = 1'b0;
        div_d   = '0;
        qtr_d   = '0;
        bit_d   = '0;
      end
    end else begin
      div_d = w_tick ? '0 : div_q + c_DIV_W'(1);
      if (w_tick) begin
        qtr_d = qtr_q + 2'd1;
      end
      if (w_tick && (qtr_q == 2'd2) && w_ack_slot && bus.i_sda_in) begin
        nack_d = 1'b1;
      end
      if (w_slot_end) begin
        case (state_q)
          ST_START: state_d = ST_ADDR;
          ST_ADDR: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = ST_ACK_A;
          end
          ST_ACK_A: state_d = nack_q ? ST_STOP : ST_DATA_H;
          ST_DATA_H: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = ST_ACK_H;
          end
          ST_ACK_H: state_d = nack_q ? ST_STOP : ST_DATA_L;
          ST_DATA_L: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = ST_ACK_L;
          end
          ST_ACK_L: state_d = ST_STOP;
          ST_STOP: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Bus waveform decode; bits change only at q0 while SCL is low
  always_comb begin
    w_scl    = 1'b1;
    w_sda    = 1'b1;
    w_scl_en = 1'b0;
    w_sda_en = 1'b0;
    case (state_q)
      ST_START: begin
        w_scl_en = 1'b1;
        w_sda_en = 1'b1;
        w_sda    = ~qtr_q[1];
      end
      ST_ADDR, ST_DATA_H, ST_DATA_L: begin
        w_scl_en = 1'b1;
        w_sda_en = 1'b1;
        w_scl    = qtr_q[1];
        w_sda    = w_bit;
      end
      ST_ACK_A, ST_ACK_H, ST_ACK_L: begin
        w_scl_en = 1'b1;
        w_scl    = qtr_q[1];
      end
      ST_STOP: begin
        w_scl_en = 1'b1;
        w_sda_en = 1'b1;
        w_scl    = (qtr_q != 2'd0);
        w_sda    = qtr_q[1];
      end
      default: begin
        w_scl    = 1'b1;
        w_sda    = 1'b1;
      end
    endcase
  end

  assign bus.o_scl    = w_scl;
  assign bus.o_sda    = w_sda;
  assign bus.o_scl_en = w_scl_en;
  assign bus.o_sda_en = w_sda_en;
  assign bus.o_busy   = (state_q != ST_IDLE);
  assign bus.o_done   = done_q;
  assign bus.o_nack   = nack_q;
  assign bus.o_data   = data_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_master_wr_ctrl
//  Description : Self-checking bench for i2c_master_wr_ctrl. DUT1 runs at
//                CLK_DIV=4, DUT2 at CLK_DIV=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_master_wr_ctrl;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  always #5 i_clk = ~i_clk;

  i2c_master_wr_ctrl_if #(.ADDR_W(7)) bus1 ();
  i2c_master_wr_ctrl_if #(.ADDR_W(7)) bus2 ();

  i2c_master_wr_ctrl #(.CLK_DIV(4), .ADDR_W(7)) u_dut1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus1)
  );

  i2c_master_wr_ctrl #(.CLK_DIV(2), .ADDR_W(7)) u_dut2 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus2)
  );

  typedef struct {
    logic [6:0]  addr;
    logic [15:0] data;
    logic [2:0]  ack_pat;   // bit0 ACK_A, bit1 ACK_H, bit2 ACK_L; 1 = NACK
    int          exp_nbits; // SCL-rise samples with SDA driven, incl. STOP q1
    logic [31:0] exp_bits;
    logic        exp_nack;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[4];
  vec_t vpost;

  int checks = 0;
  int errors = 0;

  // DUT1 bus monitor state
  logic [2:0]  ack_pat     = 3'b000;
  int          m_cyc       = 0;
  int          m_nbits     = 0;
  int          m_starts    = 0;
  int          m_stops     = 0;
  int          m_ack_idx   = 0;
  logic [31:0] m_bits      = '0;
  logic        m_prev_scl  = 1'b1;
  logic        m_prev_sda  = 1'b1;
  logic        m_busy_prev = 1'b0;

  // DUT2 busy-length monitor
  int          m2_cyc       = 0;
  logic        m2_busy_prev = 1'b0;

  // DUT1: records SDA at each SCL rise, counts SDA edges under SCL high,
  // and plays the slave's ACK/NACK response into each ACK slot
  always @(negedge i_clk) begin
    if (bus1.o_busy && !m_busy_prev) begin
      m_cyc     = 0;
      m_nbits   = 0;
      m_bits    = '0;
      m_starts  = 0;
      m_stops   = 0;
      m_ack_idx = 0;
    end
    if (bus1.o_busy) m_cyc++;
    if (m_prev_scl && bus1.o_scl && (bus1.o_sda != m_prev_sda)) begin
      if (!bus1.o_sda) m_starts++;
      else             m_stops++;
    end
    if (!m_prev_scl && bus1.o_scl) begin
      if (bus1.o_sda_en) begin
        m_bits = {m_bits[30:0], bus1.o_sda};
        m_nbits++;
      end else begin
        if (m_ack_idx < 3) bus1.i_sda_in = ack_pat[m_ack_idx];
        m_ack_idx++;
      end
    end
    m_prev_scl  = bus1.o_scl;
    m_prev_sda  = bus1.o_sda;
    m_busy_prev = bus1.o_busy;
  end

  // DUT2: length of each busy window
  always @(negedge i_clk) begin
    if (bus2.o_busy && !m2_busy_prev) m2_cyc = 0;
    if (bus2.o_busy) m2_cyc++;
    m2_busy_prev = bus2.o_busy;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int which, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge i_clk);
      if (((which == 1) ? bus1.o_done : bus2.o_done) == 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    ack_pat = v.ack_pat;
    @(negedge i_clk);
    bus1.i_addr  = v.addr;
    bus1.i_data  = v.data;
    bus1.i_start = 1'b1;
    @(negedge i_clk);
    bus1.i_start = 1'b0;
    chk({tag, "_busy"}, {31'd0, bus1.o_busy}, 32'd1);
    wait_done(1, tag);
    chk({tag, "_idle_at_done"}, {28'd0, bus1.o_busy, bus1.o_scl_en, bus1.o_sda_en, bus1.o_scl}, 32'd1);
    chk({tag, "_nack"},   {31'd0, bus1.o_nack}, {31'd0, v.exp_nack});
    chk({tag, "_cycles"}, m_cyc,    v.exp_cyc);
    chk({tag, "_nbits"},  m_nbits,  v.exp_nbits);
    chk({tag, "_bits"},   m_bits,   v.exp_bits);
    chk({tag, "_starts"}, m_starts, 32'd1);
    chk({tag, "_stops"},  m_stops,  32'd1);
    chk({tag, "_odata"},  {16'd0, bus1.o_data}, {16'd0, v.data});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bus"},  {28'd0, bus1.o_scl, bus1.o_sda, bus1.o_scl_en, bus1.o_sda_en}, 32'hC);
    chk({tag, "_host"}, {29'd0, bus1.o_busy, bus1.o_done, bus1.o_nack}, 32'd0);
    chk({tag, "_data"}, {16'd0, bus1.o_data}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // addr, data, ack_pat, nbits, bits (addr+W, bytes, trailing STOP 0), nack, cycles
    vecs[0] = '{7'h50, 16'hA53C, 3'b000, 25, 32'(25'b1010000_0_10100101_00111100_0), 1'b0, 464};
    vecs[1] = '{7'h50, 16'hA53C, 3'b001,  9, 32'(9'b1010000_0_0),                    1'b1, 176};
    vecs[2] = '{7'h13, 16'h5A01, 3'b100, 25, 32'(25'b0010011_0_01011010_00000001_0), 1'b1, 464};
    vecs[3] = '{7'h2A, 16'h0FF0, 3'b010, 17, 32'(17'b0101010_0_00001111_0),          1'b1, 320};
    vpost   = '{7'h44, 16'h0F0F, 3'b000, 25, 32'(25'b1000100_0_00001111_00001111_0), 1'b0, 464};

    bus1.i_start  = 1'b0;
    bus1.i_addr   = '0;
    bus1.i_data   = '0;
    bus1.i_sda_in = 1'b0;
    bus2.i_start  = 1'b0;
    bus2.i_addr   = '0;
    bus2.i_data   = '0;
    bus2.i_sda_in = 1'b0;

    // Reset state
    repeat (3) @(negedge i_clk);
    chk_reset_outputs("reset");
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("idle_after_reset", {30'd0, bus1.o_busy, bus1.o_scl_en}, 32'd0);

    // Table-driven transactions
    for (int i = 0; i < 4; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // i_start held for a whole transaction: one transaction, then re-accept in done cycle
    ack_pat = 3'b000;
    @(negedge i_clk);
    bus1.i_addr  = 7'h50;
    bus1.i_data  = 16'hA53C;
    bus1.i_start = 1'b1;
    @(negedge i_clk);
    bus1.i_data  = 16'h0001;
    wait_done(1, "hold1");
    chk("hold1_cycles", m_cyc, 464);
    chk("hold1_starts", m_starts, 1);
    chk("hold1_stops",  m_stops, 1);
    chk("hold1_odata",  {16'd0, bus1.o_data}, 32'hA53C);
    @(negedge i_clk);
    chk("hold_reaccept_busy", {31'd0, bus1.o_busy}, 32'd1);
    chk("hold_reaccept_data", {16'd0, bus1.o_data}, 32'h0001);
    bus1.i_start = 1'b0;
    wait_done(1, "hold2");
    chk("hold2_cycles", m_cyc, 464);
    chk("hold2_bits",   m_bits, 32'(25'b1010000_0_00000000_00000001_0));

    // Asynchronous reset in the middle of the high data byte
    ack_pat = 3'b000;
    @(negedge i_clk);
    bus1.i_addr  = 7'h50;
    bus1.i_data  = 16'hA53C;
    bus1.i_start = 1'b1;
    @(negedge i_clk);
    bus1.i_start = 1'b0;
    for (int i = 0; i < 2000 && m_nbits < 12; i++) @(negedge i_clk);
    chk("rst_mid_reached", {31'd0, (m_nbits >= 12)}, 32'd1);
    chk("rst_mid_sda_en", {31'd0, bus1.o_sda_en}, 32'd1);
    #2 i_rst_n = 1'b0;
    #1 chk_reset_outputs("rst_async");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_vec("post_rst", vpost);

    // CLK_DIV=2 back-to-back to address 0x7F
    @(negedge i_clk);
    bus2.i_addr  = 7'h7F;
    bus2.i_data  = 16'h1234;
    bus2.i_start = 1'b1;
    wait_done(2, "d2_first");
    chk("d2_first_cycles", m2_cyc, 232);
    chk("d2_first_odata",  {16'd0, bus2.o_data}, 32'h1234);
    chk("d2_first_nack",   {31'd0, bus2.o_nack}, 32'd0);
    bus2.i_data = 16'hFFFF;
    @(negedge i_clk);
    chk("d2_reaccept_busy",  {31'd0, bus2.o_busy}, 32'd1);
    chk("d2_reaccept_odata", {16'd0, bus2.o_data}, 32'hFFFF);
    bus2.i_start = 1'b0;
    wait_done(2, "d2_second");
    chk("d2_second_cycles", m2_cyc, 232);
    chk("d2_second_odata",  {16'd0, bus2.o_data}, 32'hFFFF);
    chk("d2_second_nack",   {31'd0, bus2.o_nack}, 32'd0);

    repeat (2) @(negedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
